// File: rtl/seg_pkg.sv
// Shared glyph constants and FSM state type for the binary-to-7-segment path.
// Glyphs are active-low, bit order g..a.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index 0 is the rightmost entry
  localparam logic [9:0][6:0] SEG_GLYPH = {
    7'b0010000,
    7'b0000000,
    7'b1111000,
    7'b0000010,
    7'b0010010,
    7'b0011001,
    7'b0110000,
    7'b0100100,
    7'b1111001,
    7'b1000000
  };

endpackage

// File: rtl/seg7_digit.sv
// One BCD nibble to one active-low 7-segment glyph.
// Non-decimal codes render blank.
module seg7_digit
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i <= 4'd9) seg_o = SEG_GLYPH[bcd_i];
  end

endmodule

// File: rtl/bin_to_seg.sv
// Serial double-dabble binary-to-BCD converter driving 7-segment glyphs.
// Define BIN_TO_SEG_LZB_EN to blank leading zero digits.
module bin_to_seg
  import seg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     data,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   segments
);

  localparam int INT_DIGITS = (DATA_W + 2) / 3;
  localparam int BCD_W      = 4 * INT_DIGITS;
  localparam int CNT_W      = $clog2(DATA_W + 1);

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7*DIGITS-1:0]   seg_q, seg_d, seg_new;
  logic                  ovf_q, ovf_d, ovf_new;
  logic                  done_q, done_d;
  logic [3:0]            nib   [DIGITS];
  logic [6:0]            glyph [DIGITS];
  logic                  unused_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= '1;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONVERT;
      CONVERT: if (cnt_q == CNT_W'(1)) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = done_q;
    ovf      = ovf_q;
    segments = seg_q;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // The adjusted MSB is always zero since INT_DIGITS covers 2^DATA_W-1
  assign unused_msb = bcd_adj[BCD_W-1];

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    seg_d  = seg_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d = data;
          bcd_d = '0;
          cnt_d = CNT_W'(DATA_W);
        end
      end
      CONVERT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_d = {bin_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
      end
      LOAD: begin
        seg_d  = seg_new;
        ovf_d  = ovf_new;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    if (g < INT_DIGITS) begin : g_nib
      assign nib[g] = bcd_q[4*g +: 4];
    end else begin : g_zero
      assign nib[g] = 4'd0;
    end
    seg7_digit u_digit (
      .bcd_i (nib[g]),
      .seg_o (glyph[g])
    );
  end

  always_comb begin
    ovf_new = 1'b0;
    for (int j = DIGITS; j < INT_DIGITS; j++) begin
      if (bcd_q[4*j +: 4] != 4'd0) ovf_new = 1'b1;
    end
  end

`ifdef BIN_TO_SEG_LZB_EN
  logic [DIGITS-1:0] lead;
  logic              zero_run;

  always_comb begin
    lead     = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (nib[k] != 4'd0) zero_run = 1'b0;
      lead[k] = zero_run;
    end
  end
`endif

  always_comb begin
    seg_new = '1;
    for (int i = 0; i < DIGITS; i++) begin
      seg_new[7*i +: 7] = glyph[i];
`ifdef BIN_TO_SEG_LZB_EN
      if (lead[i]) seg_new[7*i +: 7] = SEG_BLANK;
`endif
      if (ovf_new) seg_new[7*i +: 7] = SEG_DASH;
    end
  end

endmodule

// File: tb/tb_bin_to_seg.sv
// Directed bench for bin_to_seg: 3-digit and 2-digit instances share stimulus.
// Expectations follow BIN_TO_SEG_LZB_EN when defined.
module tb_bin_to_seg;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  data;
  logic        busy3, done3, ovf3;
  logic [20:0] seg3;
  logic        busy2, done2, ovf2;
  logic [13:0] seg2;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [6:0] G [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  typedef struct {
    logic [7:0] v;
    int         d2;
    int         d1;
    int         d0;
  } vec_t;

  vec_t tbl [13];

  bin_to_seg #(.DATA_W(8), .DIGITS(3)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data     (data),
    .busy     (busy3),
    .done     (done3),
    .ovf      (ovf3),
    .segments (seg3)
  );

  bin_to_seg #(.DATA_W(8), .DIGITS(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data     (data),
    .busy     (busy2),
    .done     (done2),
    .ovf      (ovf2),
    .segments (seg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] exp3(input int d2, input int d1, input int d0);
    logic [6:0] g2, g1;
    g2 = G[d2];
    g1 = G[d1];
`ifdef BIN_TO_SEG_LZB_EN
    if (d2 == 0) g2 = BLANK;
    if (d2 == 0 && d1 == 0) g1 = BLANK;
`endif
    return {g2, g1, G[d0]};
  endfunction

  function automatic logic [13:0] exp2(input int v, input int d1, input int d0);
    logic [6:0] g1;
    if (v > 99) return {DASH, DASH};
    g1 = G[d1];
`ifdef BIN_TO_SEG_LZB_EN
    if (d1 == 0) g1 = BLANK;
`endif
    return {g1, G[d0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input logic [7:0] v, output int lat);
    @(negedge clk);
    data  = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    data  = ~v;
    lat   = 0;
    while (!done3 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int npulse;
    logic [20:0] hold;

    tbl[0]  = '{8'd255, 2, 5, 5};
    tbl[1]  = '{8'd0,   0, 0, 0};
    tbl[2]  = '{8'd1,   0, 0, 1};
    tbl[3]  = '{8'd9,   0, 0, 9};
    tbl[4]  = '{8'd10,  0, 1, 0};
    tbl[5]  = '{8'd99,  0, 9, 9};
    tbl[6]  = '{8'd100, 1, 0, 0};
    tbl[7]  = '{8'd128, 1, 2, 8};
    tbl[8]  = '{8'd200, 2, 0, 0};
    tbl[9]  = '{8'd42,  0, 4, 2};
    tbl[10] = '{8'd7,   0, 0, 7};
    tbl[11] = '{8'd63,  0, 6, 3};
    tbl[12] = '{8'd150, 1, 5, 0};

    rst   = 1'b1;
    start = 1'b0;
    data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg3", 32'(seg3), 32'h1FFFFF);
    chk("rst_seg2", 32'(seg2), 32'h3FFF);
    chk("rst_busy", 32'(busy3), 0);
    chk("rst_done", 32'(done3), 0);
    chk("rst_ovf",  32'(ovf3), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run(tbl[i].v, lat);
      chk($sformatf("lat[%0d]", i), 32'(lat), 9);
      chk($sformatf("seg3[%0d]", i), 32'(seg3), 32'(exp3(tbl[i].d2, tbl[i].d1, tbl[i].d0)));
      chk($sformatf("ovf3[%0d]", i), 32'(ovf3), 0);
      chk($sformatf("seg2[%0d]", i), 32'(seg2), 32'(exp2(int'(tbl[i].v), tbl[i].d1, tbl[i].d0)));
      chk($sformatf("ovf2[%0d]", i), 32'(ovf2), (tbl[i].v > 8'd99) ? 1 : 0);
      chk($sformatf("done2[%0d]", i), 32'(done2), 1);
      chk($sformatf("busy_idle[%0d]", i), 32'(busy3), 0);
      @(posedge clk);
      #1;
      chk($sformatf("done_pulse[%0d]", i), 32'(done3), 0);
    end

    // Held outputs while idle with data changing
    hold = seg3;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      data = 8'(c * 37 + 5);
    end
    #1;
    chk("hold_seg3", 32'(seg3), 32'(hold));
    chk("hold_done", 32'(done3), 0);

    // Second start during a conversion is ignored
    npulse = 0;
    @(negedge clk);
    data  = 8'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_conv", 32'(busy3), 1);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      start = (c == 3);
      data  = (c == 3) ? 8'd7 : 8'd0;
      @(posedge clk);
      #1;
      if (done3) npulse++;
    end
    start = 1'b0;
    chk("ign_pulses", 32'(npulse), 1);
    chk("ign_seg3", 32'(seg3), 32'(exp3(2, 0, 0)));
    chk("ign_busy", 32'(busy3), 0);

    // Reset mid-conversion aborts the result
    @(negedge clk);
    data  = 8'd123;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy3), 0);
    chk("abort_seg3", 32'(seg3), 32'h1FFFFF);
    chk("abort_done", 32'(done3), 0);
    chk("abort_ovf2", 32'(ovf2), 0);
    @(negedge clk);
    rst = 1'b0;
    npulse = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done3) npulse++;
    end
    chk("abort_pulses", 32'(npulse), 0);
    chk("abort_blank", 32'(seg3), 32'h1FFFFF);
    run(8'd77, lat);
    chk("post_lat", 32'(lat), 9);
    chk("post_seg3", 32'(seg3), 32'(exp3(0, 7, 7)));
    chk("post_seg2", 32'(seg2), 32'(exp2(77, 7, 7)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
